// File: rtl/countdown_timer.sv
// countdown_timer
//   Loadable WIDTH-bit down-counter decremented once per prescaler period
//   (DIV = CLK_HZ / TICK_HZ clocks). Supports start/pause/resume, stops at zero
//   and can optionally auto-reload on expiry.
//
// Ports
//   Clk          system clock, rising edge
//   Reset_n      asynchronous active-low reset
//   Load         load Load_value into count and reload register (highest priority)
//   Load_value   value captured on Load
//   Start        start from IDLE/DONE (count != 0) or resume from PAUSED
//   Pause        freeze count and prescaler while running
//   Auto_reload  on expiry reload the count and keep running
//   tick         1-cycle pulse per prescaler wrap while running
//   expired      1-cycle pulse when the count reaches zero
//   running      high while in RUN
//   count_out    current count
module countdown_timer #(
    parameter int unsigned CLK_HZ  = 50_000_000,
    parameter int unsigned TICK_HZ = 1,
    parameter int unsigned WIDTH   = 32
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Load,
    input  logic [WIDTH-1:0] Load_value,
    input  logic             Start,
    input  logic             Pause,
    input  logic             Auto_reload,
    output logic             tick,
    output logic             expired,
    output logic             running,
    output logic [WIDTH-1:0] count_out
);

    localparam int unsigned DIV = CLK_HZ / TICK_HZ;
    localparam int unsigned PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRESC_TOP = PW'(DIV - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StPaused,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic             tick_int_q, tick_int_d;
    logic             tick_q, tick_d;
    logic             expired_q, expired_d;
    logic             running_q;
    logic             stop;

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        reload_d   = reload_q;
        presc_d    = presc_q;
        tick_int_d = 1'b0;
        tick_d     = 1'b0;
        expired_d  = 1'b0;
        stop       = 1'b0;

        if (Load) begin
            // Load also discards any tick still pending from the prescaler.
            count_d  = Load_value;
            reload_d = Load_value;
            presc_d  = PRESC_TOP;
            state_d  = StIdle;
        end else begin
            // A tick raised on the previous edge always completes, even if the
            // state leaves RUN on this edge.
            if (tick_int_q) begin
                tick_d = 1'b1;
                if (count_q > WIDTH'(1)) begin
                    count_d = count_q - WIDTH'(1);
                end else if (count_q == WIDTH'(1)) begin
                    expired_d = 1'b1;
                    if (Auto_reload && (reload_q != '0)) begin
                        count_d = reload_q;
                    end else begin
                        count_d = '0;
                        stop    = 1'b1;
                    end
                end
            end

            unique case (state_q)
                StIdle, StDone: begin
                    if (Start && (count_q != '0)) begin
                        state_d = StRun;
                        presc_d = PRESC_TOP;
                    end
                end
                StRun: begin
                    if (Pause) begin
                        state_d = StPaused;
                    end else if (presc_q == '0) begin
                        presc_d    = PRESC_TOP;
                        tick_int_d = 1'b1;
                    end else begin
                        presc_d = presc_q - PW'(1);
                    end
                end
                StPaused: begin
                    // Resume keeps the partially elapsed prescaler period.
                    if (Start) begin
                        state_d = StRun;
                    end
                end
                default: state_d = StIdle;
            endcase

            if (stop) begin
                state_d = StDone;
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q    <= StIdle;
            count_q    <= '0;
            reload_q   <= '0;
            presc_q    <= PRESC_TOP;
            tick_int_q <= 1'b0;
            tick_q     <= 1'b0;
            expired_q  <= 1'b0;
            running_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            reload_q   <= reload_d;
            presc_q    <= presc_d;
            tick_int_q <= tick_int_d;
            tick_q     <= tick_d;
            expired_q  <= expired_d;
            running_q  <= (state_d == StRun);
        end
    end

    assign tick      = tick_q;
    assign expired   = expired_q;
    assign running   = running_q;
    assign count_out = count_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer with DIV = 4, WIDTH = 8. Stimulus pushes the
// expected tick/expired events (cycle, count, expired, running) into a queue;
// a monitor pops and compares each time the DUT pulses tick or expired.
module tb_countdown_timer;

    localparam int unsigned WIDTH = 8;

    logic             Clk = 1'b0;
    logic             Reset_n;
    logic             Load;
    logic [WIDTH-1:0] Load_value;
    logic             Start;
    logic             Pause;
    logic             Auto_reload;
    logic             tick;
    logic             expired;
    logic             running;
    logic [WIDTH-1:0] count_out;

    typedef struct {
        int cyc;
        int cnt;
        bit ex;
        bit run;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_pass   = 0;

    countdown_timer #(
        .CLK_HZ (8),
        .TICK_HZ(2),
        .WIDTH  (WIDTH)
    ) dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .Load       (Load),
        .Load_value (Load_value),
        .Start      (Start),
        .Pause      (Pause),
        .Auto_reload(Auto_reload),
        .tick       (tick),
        .expired    (expired),
        .running    (running),
        .count_out  (count_out)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic do_load(input int v);
        Load       = 1'b1;
        Load_value = WIDTH'(v);
        step(1);
        Load = 1'b0;
    endtask

    task automatic do_start();
        Start = 1'b1;
        step(1);
        Start = 1'b0;
    endtask

    task automatic push(input int c, input int cnt, input bit ex, input bit run);
        exp_t e;
        e.cyc = c;
        e.cnt = cnt;
        e.ex  = ex;
        e.run = run;
        sb_q.push_back(e);
    endtask

    // Monitor: every tick/expired pulse must match the head of the scoreboard.
    always @(negedge Clk) begin
        if (Reset_n) begin
            while (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
                check("missed_event", cyc, sb_q[0].cyc);
                void'(sb_q.pop_front());
            end
            if (tick || expired) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_event", 1, 0);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("event_cycle", cyc, mon_e.cyc);
                    check("event_tick", int'(tick), 1);
                    check("event_count", int'(count_out), mon_e.cnt);
                    check("event_expired", int'(expired), int'(mon_e.ex));
                    check("event_running", int'(running), int'(mon_e.run));
                end
            end
        end
    end

    initial begin
        int n;
        Reset_n     = 1'b1;
        Load        = 1'b0;
        Load_value  = '0;
        Start       = 1'b0;
        Pause       = 1'b0;
        Auto_reload = 1'b0;
        #2;
        Reset_n = 1'b0;
        step(3);
        check("reset_count", int'(count_out), 0);
        check("reset_running", int'(running), 0);
        check("reset_tick", int'(tick), 0);
        check("reset_expired", int'(expired), 0);
        Reset_n = 1'b1;
        step(2);

        // Load 3, run to expiry: 3 ticks, one expired, then DONE.
        do_load(3);
        check("load3_count", int'(count_out), 3);
        check("load3_running", int'(running), 0);
        do_start();
        n = cyc;
        check("start_running", int'(running), 1);
        push(n + 5, 2, 1'b0, 1'b1);
        push(n + 9, 1, 1'b0, 1'b1);
        push(n + 13, 0, 1'b1, 1'b0);
        step(16);
        check("done_count", int'(count_out), 0);
        check("done_running", int'(running), 0);
        do_start();
        step(6);
        check("done_start_running", int'(running), 0);

        // Start on a zero count stays idle.
        do_load(0);
        do_start();
        step(6);
        check("zero_start_running", int'(running), 0);
        check("zero_start_count", int'(count_out), 0);

        // Load 5, pause after the first decrement, then resume.
        do_load(5);
        do_start();
        n = cyc;
        push(n + 5, 4, 1'b0, 1'b1);
        step(5);
        Pause = 1'b1;
        step(1);
        Pause = 1'b0;
        check("pause_running", int'(running), 0);
        step(8);
        check("pause_hold_count", int'(count_out), 4);
        check("pause_hold_running", int'(running), 0);
        do_start();
        n = cyc;
        check("resume_running", int'(running), 1);
        // Prescaler resumes from 2, so the next decrement is 4 edges out.
        push(n + 4, 3, 1'b0, 1'b1);
        push(n + 8, 2, 1'b0, 1'b1);
        push(n + 12, 1, 1'b0, 1'b1);
        push(n + 16, 0, 1'b1, 1'b0);
        step(18);

        // Auto-reload: 2,1,2,1,... with an expired pulse every 8 cycles.
        Auto_reload = 1'b1;
        do_load(2);
        do_start();
        n = cyc;
        push(n + 5, 1, 1'b0, 1'b1);
        push(n + 9, 2, 1'b1, 1'b1);
        push(n + 13, 1, 1'b0, 1'b1);
        push(n + 17, 2, 1'b1, 1'b1);
        push(n + 21, 1, 1'b0, 1'b1);
        push(n + 25, 2, 1'b1, 1'b1);
        step(26);
        check("autoreload_running", int'(running), 1);

        // Load during RUN aborts to IDLE with the new value.
        do_load(200);
        check("load200_count", int'(count_out), 200);
        check("load200_running", int'(running), 0);
        Auto_reload = 1'b0;
        step(10);
        check("load200_hold", int'(count_out), 200);
        do_start();
        n = cyc;
        push(n + 5, 199, 1'b0, 1'b1);
        step(7);

        // Reset mid-run clears everything immediately.
        Reset_n = 1'b0;
        #1;
        check("midreset_count", int'(count_out), 0);
        check("midreset_running", int'(running), 0);
        check("midreset_tick", int'(tick), 0);
        check("midreset_expired", int'(expired), 0);
        step(2);
        Reset_n = 1'b1;
        step(3);
        check("postreset_count", int'(count_out), 0);
        check("postreset_running", int'(running), 0);
        do_start();
        step(6);
        check("postreset_start_running", int'(running), 0);

        // Load and Start together: Load wins, no ticks.
        Load       = 1'b1;
        Load_value = 8'd7;
        Start      = 1'b1;
        step(1);
        Load  = 1'b0;
        Start = 1'b0;
        check("loadstart_running", int'(running), 0);
        check("loadstart_count", int'(count_out), 7);
        step(8);
        check("loadstart_hold_count", int'(count_out), 7);
        check("loadstart_hold_running", int'(running), 0);

        step(2);
        check("scoreboard_empty", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
